// File: rtl/sprite_line_engine_if.sv
// Register bus carrying sprite programming writes from the CPU side into the engine.
// Latency: pure wiring, no storage.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
interface sprite_line_engine_if;
  logic        register_write_i;
  logic [11:0] register_index_i;
  logic [15:0] register_write_value_i;

  modport master (
    output register_write_i,
    output register_index_i,
    output register_write_value_i
  );

  modport slave (
    input register_write_i,
    input register_index_i,
    input register_write_value_i
  );
endinterface

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite detector: scans all sprites into a slot list, matches raster_x against it.
// Latency: display outputs one cycle after raster_x; scan takes NUM_SPRITES cycles after line_start.
// Backpressure: none; register writes and raster inputs are consumed every cycle.
module sprite_line_engine #(
  parameter  int NUM_SPRITES = 8,
  parameter  int SLOTS       = 4,
  parameter  int SIZE_LOG2   = 4,
  parameter  int SHAPE_BITS  = 4,
  parameter  int BASE_INDEX  = 0,
  localparam int IDXW        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int AW          = SHAPE_BITS + 2 * SIZE_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            raster_x,
  input  logic [9:0]            raster_y,
  input  logic                  line_start,
  sprite_line_engine_if.slave   bus,
  output logic                  sprite_active,
  output logic [AW-1:0]         sprite_address,
  output logic [IDXW-1:0]       sprite_index,
  output logic                  line_overflow
);

  localparam int         CW   = $clog2(SLOTS + 1);
  localparam logic [9:0] EDGE = 10'(1 << SIZE_LOG2);

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;

  // Sprite register file
  logic [9:0]            spr_x_q     [NUM_SPRITES];
  logic [9:0]            spr_y_q     [NUM_SPRITES];
  logic [SHAPE_BITS-1:0] spr_shape_q [NUM_SPRITES];
  logic                  spr_hflip_q [NUM_SPRITES];
  logic                  spr_vflip_q [NUM_SPRITES];
  logic                  spr_en_q    [NUM_SPRITES];

  // Active (displayed line) and pending (next line) slot lists
  logic                  act_vld_q   [SLOTS];
  logic [IDXW-1:0]       act_idx_q   [SLOTS];
  logic [9:0]            act_x_q     [SLOTS];
  logic [SHAPE_BITS-1:0] act_shape_q [SLOTS];
  logic                  act_hflip_q [SLOTS];
  logic [SIZE_LOG2-1:0]  act_yoff_q  [SLOTS];
  logic                  pend_vld_q   [SLOTS];
  logic [IDXW-1:0]       pend_idx_q   [SLOTS];
  logic [9:0]            pend_x_q     [SLOTS];
  logic [SHAPE_BITS-1:0] pend_shape_q [SLOTS];
  logic                  pend_hflip_q [SLOTS];
  logic [SIZE_LOG2-1:0]  pend_yoff_q  [SLOTS];
  logic [CW-1:0]         pend_cnt_q;
  logic                  pend_ovf_q;
  logic                  ovf_q;
  logic [9:0]            tgt_q;
  logic [IDXW-1:0]       cnt_q;

  logic                  active_q;
  logic [AW-1:0]         addr_q;
  logic [IDXW-1:0]       index_q;

  // Register bus decode; a negative relative index sets bit 12 and is rejected
  logic [12:0]     rel;
  logic            wr_hit;
  logic [IDXW-1:0] wr_n;
  logic [1:0]      wr_k;
  assign rel    = {1'b0, bus.register_index_i} - 13'(BASE_INDEX);
  assign wr_hit = bus.register_write_i && !rel[12] && (rel < 13'(4 * NUM_SPRITES));
  assign wr_n   = rel[IDXW+1:2];
  assign wr_k   = rel[1:0];

  // Scan evaluation of the sprite addressed by the counter
  logic [9:0]           scan_dy;
  logic                 scan_hit;
  logic                 scan_last;
  logic [SIZE_LOG2-1:0] scan_yoff;
  assign scan_dy   = tgt_q - spr_y_q[cnt_q];
  assign scan_hit  = (state_q == SCAN) && spr_en_q[cnt_q] && (scan_dy < EDGE);
  assign scan_last = (cnt_q == IDXW'(NUM_SPRITES - 1));
  assign scan_yoff = spr_vflip_q[cnt_q] ? ~scan_dy[SIZE_LOG2-1:0] : scan_dy[SIZE_LOG2-1:0];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: line_start always (re)starts a scan
  always_comb begin
    state_d = state_q;
    if (line_start)                          state_d = SCAN;
    else if (state_q == SCAN && scan_last)   state_d = IDLE;
  end

  // Sprite register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_SPRITES; n++) begin
        spr_x_q[n]     <= '0;
        spr_y_q[n]     <= '0;
        spr_shape_q[n] <= '0;
        spr_hflip_q[n] <= 1'b0;
        spr_vflip_q[n] <= 1'b0;
        spr_en_q[n]    <= 1'b0;
      end
    end else if (wr_hit) begin
      case (wr_k)
        2'd0: spr_x_q[wr_n] <= bus.register_write_value_i[9:0];
        2'd1: spr_y_q[wr_n] <= bus.register_write_value_i[9:0];
        2'd2: begin
          spr_shape_q[wr_n] <= bus.register_write_value_i[SHAPE_BITS-1:0];
          spr_hflip_q[wr_n] <= bus.register_write_value_i[8];
          spr_vflip_q[wr_n] <= bus.register_write_value_i[9];
        end
        default: spr_en_q[wr_n] <= (bus.register_write_value_i != 16'd0);
      endcase
    end
  end

  // Slot lists: swap on line_start, fill pending list one sprite per scan cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        act_vld_q[s]    <= 1'b0;
        act_idx_q[s]    <= '0;
        act_x_q[s]      <= '0;
        act_shape_q[s]  <= '0;
        act_hflip_q[s]  <= 1'b0;
        act_yoff_q[s]   <= '0;
        pend_vld_q[s]   <= 1'b0;
        pend_idx_q[s]   <= '0;
        pend_x_q[s]     <= '0;
        pend_shape_q[s] <= '0;
        pend_hflip_q[s] <= 1'b0;
        pend_yoff_q[s]  <= '0;
      end
      pend_cnt_q <= '0;
      pend_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      tgt_q      <= '0;
      cnt_q      <= '0;
    end else if (line_start) begin
      for (int s = 0; s < SLOTS; s++) begin
        act_vld_q[s]   <= pend_vld_q[s];
        act_idx_q[s]   <= pend_idx_q[s];
        act_x_q[s]     <= pend_x_q[s];
        act_shape_q[s] <= pend_shape_q[s];
        act_hflip_q[s] <= pend_hflip_q[s];
        act_yoff_q[s]  <= pend_yoff_q[s];
        pend_vld_q[s]  <= 1'b0;
      end
      ovf_q      <= pend_ovf_q;
      pend_ovf_q <= 1'b0;
      pend_cnt_q <= '0;
      tgt_q      <= raster_y + 10'd1;
      cnt_q      <= '0;
    end else if (state_q == SCAN) begin
      cnt_q <= cnt_q + 1'b1;
      if (scan_hit) begin
        if (pend_cnt_q < CW'(SLOTS)) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (CW'(s) == pend_cnt_q) begin
              pend_vld_q[s]   <= 1'b1;
              pend_idx_q[s]   <= cnt_q;
              pend_x_q[s]     <= spr_x_q[cnt_q];
              pend_shape_q[s] <= spr_shape_q[cnt_q];
              pend_hflip_q[s] <= spr_hflip_q[cnt_q];
              pend_yoff_q[s]  <= scan_yoff;
            end
          end
          pend_cnt_q <= pend_cnt_q + 1'b1;
        end else begin
          pend_ovf_q <= 1'b1;
        end
      end
    end
  end

  // Display match: walk slots high to low so the lowest matching slot wins
  logic                  hit_any;
  logic [AW-1:0]         hit_addr;
  logic [IDXW-1:0]       hit_idx;
  always_comb begin : display_match
    logic [9:0]           dx;
    logic [SIZE_LOG2-1:0] xoff;
    hit_any  = 1'b0;
    hit_addr = '0;
    hit_idx  = '0;
    dx       = '0;
    xoff     = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      dx   = raster_x - act_x_q[s];
      xoff = act_hflip_q[s] ? ~dx[SIZE_LOG2-1:0] : dx[SIZE_LOG2-1:0];
      if (act_vld_q[s] && (dx < EDGE)) begin
        hit_any  = 1'b1;
        hit_addr = {act_shape_q[s], act_yoff_q[s], xoff};
        hit_idx  = act_idx_q[s];
      end
    end
  end

  // Registered pixel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      index_q  <= '0;
    end else begin
      active_q <= hit_any;
      addr_q   <= hit_addr;
      index_q  <= hit_idx;
    end
  end

  assign sprite_active  = active_q;
  assign sprite_address = addr_q;
  assign sprite_index   = index_q;
  assign line_overflow  = ovf_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with default parameters (8 sprites, 4 slots, 16-px sprites).
// Latency: checks outputs one cycle after each raster_x.
// Backpressure: none.
module tb_sprite_line_engine;
  logic        clk;
  logic        reset_n;
  logic [9:0]  raster_x;
  logic [9:0]  raster_y;
  logic        line_start;
  logic        sprite_active;
  logic [11:0] sprite_address;
  logic [2:0]  sprite_index;
  logic        line_overflow;

  int ncmp  = 0;
  int nfail = 0;

  sprite_line_engine_if bus_if ();

  sprite_line_engine dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .raster_x       (raster_x),
    .raster_y       (raster_y),
    .line_start     (line_start),
    .bus            (bus_if),
    .sprite_active  (sprite_active),
    .sprite_address (sprite_address),
    .sprite_index   (sprite_index),
    .line_overflow  (line_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int val);
    bus_if.register_write_i      = 1'b1;
    bus_if.register_index_i      = 12'(idx);
    bus_if.register_write_value_i = 16'(val);
    tick();
    bus_if.register_write_i      = 1'b0;
  endtask

  task automatic program_sprite(input int n, input int x, input int y, input int shp, input int en);
    wr(4 * n + 0, x);
    wr(4 * n + 1, y);
    wr(4 * n + 2, shp);
    wr(4 * n + 3, en);
  endtask

  // line_start during line y, then let the scan for y+1 complete
  task automatic new_line(input int y);
    raster_y   = 10'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
  endtask

  task automatic chk_pix(input string tag, input int x, input int ea, input int eaddr, input int eidx);
    raster_x = 10'(x);
    tick();
    chk($sformatf("%s.x%0d.act", tag, x), 32'(sprite_active), 32'(ea));
    chk($sformatf("%s.x%0d.addr", tag, x), 32'(sprite_address), 32'(eaddr));
    chk($sformatf("%s.x%0d.idx", tag, x), 32'(sprite_index), 32'(eidx));
  endtask

  initial begin
    reset_n = 1'b0;
    raster_x = '0;
    raster_y = '0;
    line_start = 1'b0;
    bus_if.register_write_i = 1'b0;
    bus_if.register_index_i = '0;
    bus_if.register_write_value_i = '0;
    tick();
    tick();
    chk("rst.act", 32'(sprite_active), 0);
    chk("rst.addr", 32'(sprite_address), 0);
    chk("rst.idx", 32'(sprite_index), 0);
    chk("rst.ovf", 32'(line_overflow), 0);
    reset_n = 1'b1;
    tick();

    // Basic sprite at (100,50), shape 3
    program_sprite(0, 100, 50, 3, 1);
    new_line(49);
    new_line(50);
    for (int x = 99; x <= 116; x++) begin
      if (x >= 100 && x <= 115) chk_pix("basic", x, 1, 'h300 + (x - 100), 0);
      else                      chk_pix("basic", x, 0, 0, 0);
    end
    chk("basic.ovf", 32'(line_overflow), 0);
    new_line(51);
    chk_pix("basic_l51", 100, 1, 'h310, 0);
    wr(3, 0);

    // Priority between sprites 1 and 5 at the same spot
    program_sprite(1, 20, 10, 1, 1);
    program_sprite(5, 20, 10, 5, 1);
    new_line(9);
    new_line(10);
    chk_pix("prio_l10", 25, 1, 'h105, 1);
    wr(4 * 1 + 3, 0);
    new_line(11);
    chk_pix("prio_l11", 25, 1, 'h115, 1);
    new_line(12);
    chk_pix("prio_l12", 25, 1, 'h525, 5);
    wr(4 * 5 + 3, 0);

    // Six sprites on one line with four slots
    for (int n = 0; n < 6; n++) program_sprite(n, 20 * n, 200, n, 1);
    new_line(199);
    new_line(200);
    chk("ovf.l200", 32'(line_overflow), 1);
    chk_pix("ovf", 5, 1, 'h005, 0);
    chk_pix("ovf", 65, 1, 'h305, 3);
    chk_pix("ovf", 85, 0, 0, 0);
    chk_pix("ovf", 105, 0, 0, 0);
    for (int n = 0; n < 6; n++) wr(4 * n + 3, 0);
    new_line(201);
    chk("ovf.l201", 32'(line_overflow), 1);
    new_line(202);
    chk("ovf.l202", 32'(line_overflow), 0);
    chk_pix("ovf_l202", 5, 0, 0, 0);

    // Both flips, shape 2 at origin
    program_sprite(0, 0, 0, 'h302, 1);
    new_line(1023);
    new_line(0);
    chk_pix("flip", 0, 1, 'h2FF, 0);
    chk_pix("flip", 15, 1, 'h2F0, 0);
    chk_pix("flip", 16, 0, 0, 0);
    chk_pix("flip", 1023, 0, 0, 0);
    wr(3, 0);

    // Wrap in both axes
    program_sprite(2, 1018, 1020, 6, 1);
    new_line(1019);
    new_line(1020);
    chk_pix("wrap_l1020", 1017, 0, 0, 0);
    chk_pix("wrap_l1020", 1018, 1, 'h600, 2);
    chk_pix("wrap_l1020", 1023, 1, 'h605, 2);
    chk_pix("wrap_l1020", 0, 1, 'h606, 2);
    chk_pix("wrap_l1020", 9, 1, 'h60F, 2);
    chk_pix("wrap_l1020", 10, 0, 0, 0);
    new_line(1023);
    new_line(0);
    chk_pix("wrap_l0", 0, 1, 'h646, 2);
    new_line(10);
    new_line(11);
    chk_pix("wrap_l11", 1018, 1, 'h6F0, 2);
    new_line(12);
    chk_pix("wrap_l12", 1018, 0, 0, 0);

    // Reset in the middle of a scan
    new_line(1022);
    raster_y   = 10'd1023;
    raster_x   = 10'd1018;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    chk("mrst.pre_act", 32'(sprite_active), 1);
    chk("mrst.pre_addr", 32'(sprite_address), 'h630);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst.act", 32'(sprite_active), 0);
    chk("mrst.addr", 32'(sprite_address), 0);
    chk("mrst.idx", 32'(sprite_index), 0);
    chk("mrst.ovf", 32'(line_overflow), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    new_line(1022);
    new_line(1023);
    chk_pix("mrst_cleared", 1018, 0, 0, 0);
    program_sprite(2, 1018, 1020, 6, 1);
    new_line(1022);
    new_line(1023);
    chk_pix("mrst_reprog", 1018, 1, 'h630, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
